// File: rtl/prog_loader.sv
// prog_loader: loads a program from tile pins into a 2^AW x DW instruction store and serves fetches.
// Optional checksum stage after the program bytes is enabled by defining PROG_CHECKSUM_EN.
module prog_loader #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_strobe,
    input  logic          ld_req,
    input  logic [AW-1:0] fetch_addr,
    output logic [DW-1:0] fetch_instr,
    output logic          cpu_run,
    output logic          ld_busy,
    output logic          err,
    output logic [AW:0]   byte_cnt
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

`ifdef PROG_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR, S_LOAD, S_CHK, S_RUN, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_HDR, S_LOAD, S_RUN, S_ERR} state_t;
`endif

    state_t           state_q, state_d;
    logic [2:0]       stb_sync, req_sync;
    logic             stb_p, req_p;
    logic [DW-1:0]    ld_byte;
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [AW:0]      len_q;
    logic [AW:0]      cnt_nxt;
    logic             hdr_ok, do_hdr, do_wr;

    // Two sync flops, an edge-history flop, and a registered pulse so the action
    // lands on the 4th clock edge after the pin edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_sync <= '0;
            req_sync <= '0;
            stb_p    <= 1'b0;
            req_p    <= 1'b0;
        end else begin
            stb_sync <= {stb_sync[1:0], ld_strobe};
            req_sync <= {req_sync[1:0], ld_req};
            stb_p    <= stb_sync[1] & ~stb_sync[2];
            req_p    <= req_sync[1] & ~req_sync[2];
        end
    end

    // Data is captured while the strobe is guaranteed high, not when the pulse acts:
    // the strobe may already have dropped (and data changed) by the action edge.
    always_ff @(posedge clk) begin
        if (stb_sync[1] & ~stb_sync[2])
            ld_byte <= ld_data;
    end

    assign cnt_nxt = byte_cnt + CNT_ONE;
    assign hdr_ok  = (ld_byte != '0) && (int'(ld_byte) <= DEPTH);

`ifdef PROG_CHECKSUM_EN
    logic [DW-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum_q <= '0;
        else if (req_p)
            sum_q <= '0;
        else if (do_wr)
            sum_q <= sum_q + ld_byte;
    end
`endif

    always_comb begin
        state_d = state_q;
        do_hdr  = 1'b0;
        do_wr   = 1'b0;
        if (req_p) begin
            state_d = S_HDR;
        end else if (stb_p) begin
            case (state_q)
                S_HDR: begin
                    if (hdr_ok) begin
                        do_hdr  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_LOAD: begin
                    do_wr = 1'b1;
                    if (cnt_nxt == len_q)
`ifdef PROG_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_RUN;
`endif
                end
`ifdef PROG_CHECKSUM_EN
                S_CHK:   state_d = (ld_byte == sum_q) ? S_RUN : S_ERR;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_HDR;
            valid_q  <= '0;
            byte_cnt <= '0;
            len_q    <= '0;
        end else begin
            state_q <= state_d;
            if (req_p) begin
                valid_q  <= '0;
                byte_cnt <= '0;
            end else if (do_hdr) begin
                len_q    <= ld_byte[AW:0];
                byte_cnt <= '0;
            end else if (do_wr) begin
                valid_q[byte_cnt[AW-1:0]] <= 1'b1;
                byte_cnt                  <= cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[byte_cnt[AW-1:0]] <= ld_byte;
    end

    assign fetch_instr = valid_q[fetch_addr] ? mem[fetch_addr] : '0;
    assign cpu_run     = (state_q == S_RUN);
    assign err         = (state_q == S_ERR);
    assign ld_busy     = ~cpu_run & ~err;
endmodule
